// File: rtl/even_odd_div_classifier.sv
// Streaming parity / divisibility classifier with a serial MSB-first remainder.
// Optional statistics counters are enabled by defining STAT_COUNTERS_EN.
module even_odd_div_classifier #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIVISOR   = 3,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_even,
  output logic                 out_div,
  output logic [WIDTH-1:0]     out_rem,
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] even_cnt,
  output logic [CNT_WIDTH-1:0] odd_cnt,
  output logic [CNT_WIDTH-1:0] div_cnt
);

  // The remainder is always < DIVISOR; one extra bit holds 2*rem+bit.
  localparam int unsigned RW = $clog2(DIVISOR);
  localparam int unsigned TW = RW + 1;
  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [WIDTH-1:0] data;
  logic [RW-1:0]  rem;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  t;
  logic [RW-1:0]  rem_nxt;

  assign in_ready = (state == IDLE);

  // One restoring-division step: shift in the next operand bit, subtract once.
  always_comb begin
    t       = {rem, data[idx]};
    rem_nxt = RW'(t);
    if (t >= TW'(DIVISOR)) begin
      rem_nxt = RW'(t - TW'(DIVISOR));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      rem       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_even  <= 1'b0;
      out_div   <= 1'b0;
      out_rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            out_even <= ~in_data[0];
            rem      <= '0;
            idx      <= IW'(WIDTH - 1);
            state    <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          idx <= idx - IW'(1);
          if (idx == '0) begin
            out_rem   <= WIDTH'(rem_nxt);
            out_div   <= (rem_nxt == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STAT_COUNTERS_EN
  logic hs;
  assign hs = out_valid && out_ready;

  // Saturating result counters; a clear request beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
      div_cnt  <= '0;
    end else if (stat_clr) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
      div_cnt  <= '0;
    end else if (hs) begin
      if (out_even && (even_cnt != '1)) even_cnt <= even_cnt + CNT_WIDTH'(1);
      if (!out_even && (odd_cnt != '1)) odd_cnt  <= odd_cnt + CNT_WIDTH'(1);
      if (out_div && (div_cnt != '1))   div_cnt  <= div_cnt + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign even_cnt = '0;
  assign odd_cnt  = '0;
  assign div_cnt  = '0;
`endif

endmodule
